mem_io_stage: RTL and testbench

- Memory stage of the single-cycle processor. Sits directly downstream of the execute stage.
- Takes the ALU-computed address and store data. Serves loads and stores to the data memory and to the memory-mapped I/O: HEX, LEDR, LEDG, KEY and SW.
- Holds the output registers that drive the board LEDs and the HEX value.
- Synchronises and debounces the KEY and SW inputs before the processor can read them.

---
 rtl/mem_io_stage.sv | 159 +++++++++++++++
 tb/tb_mem_io_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_io_stage.sv
// Memory stage: word-addressed data memory plus memory-mapped board I/O.
// KEY/SW are synchronised and debounced before the processor can see them.

module mem_io_debounce #(
    parameter int W      = 4,
    parameter int CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);
    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    logic [W-1:0]  sync1_r;
    logic [W-1:0]  sync2_r;
    logic [W-1:0]  last_r;
    logic [W-1:0]  stable_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchroniser followed by a stability counter; any mid-count change restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= {W{1'b0}};
            sync2_r  <= {W{1'b0}};
            last_r   <= {W{1'b0}};
            stable_r <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            last_r  <= sync2_r;
            if (sync2_r == stable_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (sync2_r != last_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                stable_r <= sync2_r;
                cnt_r    <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign stable = stable_r;
endmodule

module mem_io_stage #(
    parameter int DBITS           = 32,
    parameter int DMEMADDRBITS    = 13,
    parameter int DMEMWORDBITS    = 2,
    parameter int DMEMWORDS       = 2048,
    parameter     DMEM_INIT_FILE  = "",
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0] ADDR_HEX  = 32'hF000_0000,
    parameter logic [DBITS-1:0] ADDR_LEDR = 32'hF000_0004,
    parameter logic [DBITS-1:0] ADDR_LEDG = 32'hF000_0008,
    parameter logic [DBITS-1:0] ADDR_KEY  = 32'hF000_0010,
    parameter logic [DBITS-1:0] ADDR_SW   = 32'hF000_0014
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [3:0]       key_in,
    input  logic [9:0]       sw_in,
    output logic [DBITS-1:0] rd_data,
    output logic [15:0]      hex_out,
    output logic [9:0]       ledr_out,
    output logic [7:0]       ledg_out
);
    localparam int IW = DMEMADDRBITS - DMEMWORDBITS;

    logic             io_sel_s;
    logic [IW-1:0]    mem_idx_s;
    logic [3:0]       key_db_s;
    logic [9:0]       sw_db_s;
    logic [15:0]      hex_r;
    logic [9:0]       ledr_r;
    logic [7:0]       ledg_r;
    logic [DBITS-1:0] mem_r [DMEMWORDS];

    // Upper address bits beyond the decoded window are ignored, so memory aliases.
    assign io_sel_s  = (addr[31:28] == 4'hF);
    assign mem_idx_s = addr[DMEMADDRBITS-1:DMEMWORDBITS];

    // KEY is active-low on the board; invert so a pressed key reads as 1.
    mem_io_debounce #(.W(4), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (~key_in),
        .stable (key_db_s)
    );

    mem_io_debounce #(.W(10), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (sw_in),
        .stable (sw_db_s)
    );

    // Data memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !io_sel_s && !reset) begin
            mem_r[mem_idx_s] <= wr_data;
        end
    end

    // Board output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_r  <= 16'h0000;
            ledr_r <= 10'h000;
            ledg_r <= 8'h00;
        end else if (wr_en) begin
            case (addr)
                ADDR_HEX:  hex_r  <= wr_data[15:0];
                ADDR_LEDR: ledr_r <= wr_data[9:0];
                ADDR_LEDG: ledg_r <= wr_data[7:0];
                default: begin
                    hex_r  <= hex_r;
                    ledr_r <= ledr_r;
                    ledg_r <= ledg_r;
                end
            endcase
        end else begin
            hex_r  <= hex_r;
            ledr_r <= ledr_r;
            ledg_r <= ledg_r;
        end
    end

    // Load path: reads see pre-write state because all writes land at the clock edge.
    always_comb begin
        rd_data = {DBITS{1'b0}};
        if (!rd_en) begin
            rd_data = {DBITS{1'b0}};
        end else if (io_sel_s) begin
            case (addr)
                ADDR_HEX:  rd_data = {{(DBITS-16){1'b0}}, hex_r};
                ADDR_LEDR: rd_data = {{(DBITS-10){1'b0}}, ledr_r};
                ADDR_LEDG: rd_data = {{(DBITS-8){1'b0}}, ledg_r};
                ADDR_KEY:  rd_data = {{(DBITS-4){1'b0}}, key_db_s};
                ADDR_SW:   rd_data = {{(DBITS-10){1'b0}}, sw_db_s};
                default:   rd_data = {DBITS{1'b0}};
            endcase
        end else begin
            rd_data = mem_r[mem_idx_s];
        end
    end

    assign hex_out  = hex_r;
    assign ledr_out = ledr_r;
    assign ledg_out = ledg_r;
endmodule

// File: tb/tb_mem_io_stage.sv
// Directed self-checking bench for mem_io_stage with a short debounce window.

module tb_mem_io_stage;
    localparam logic [31:0] A_HEX  = 32'hF000_0000;
    localparam logic [31:0] A_LEDR = 32'hF000_0004;
    localparam logic [31:0] A_LEDG = 32'hF000_0008;
    localparam logic [31:0] A_KEY  = 32'hF000_0010;
    localparam logic [31:0] A_SW   = 32'hF000_0014;
    localparam logic [31:0] A_UNM  = 32'hF000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  key_in;
    logic [9:0]  sw_in;
    logic [31:0] rd_data;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_io_stage #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .key_in   (key_in),
        .sw_in    (sw_in),
        .rd_data  (rd_data),
        .hex_out  (hex_out),
        .ledr_out (ledr_out),
        .ledg_out (ledg_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        wr_en = 1'b0;
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 32'h0; wr_data = 32'h0; wr_en = 1'b0; rd_en = 1'b0;
        key_in = 4'hF; sw_in = 10'h000;
        repeat (3) tick();
        reset = 1'b0;

        rd(A_HEX,  "rst_rd_hex",  32'h0);
        rd(A_LEDR, "rst_rd_ledr", 32'h0);
        rd(A_LEDG, "rst_rd_ledg", 32'h0);
        rd(A_KEY,  "rst_rd_key",  32'h0);
        rd(A_SW,   "rst_rd_sw",   32'h0);
        check_eq("rst_hex_out",  {16'h0, hex_out},  32'h0);
        check_eq("rst_ledr_out", {22'h0, ledr_out}, 32'h0);
        check_eq("rst_ledg_out", {24'h0, ledg_out}, 32'h0);

        // Memory: old data visible during store cycle, new data after; alias at 0x2100
        st(32'h0000_0100, 32'h1111_2222);
        addr = 32'h0000_0100; wr_data = 32'h1234_5678; wr_en = 1'b1; rd_en = 1'b1;
        #1;
        check_eq("ld_in_store_cycle", rd_data, 32'h1111_2222);
        tick();
        wr_en = 1'b0;
        rd(32'h0000_0100, "ld_after_store", 32'h1234_5678);
        rd(32'h0000_2100, "ld_alias",       32'h1234_5678);
        rd(32'h0000_0102, "ld_byte_offset", 32'h1234_5678);
        rd_en = 1'b0;
        #1;
        check_eq("rd_en_low_zero", rd_data, 32'h0);

        st(A_HEX,  32'hFFFF_ABCD);
        st(A_LEDR, 32'h0000_03FF);
        st(A_LEDG, 32'h0000_01A5);
        check_eq("hex_out",  {16'h0, hex_out},  32'h0000_ABCD);
        check_eq("ledr_out", {22'h0, ledr_out}, 32'h0000_03FF);
        check_eq("ledg_out", {24'h0, ledg_out}, 32'h0000_00A5);
        rd(A_HEX,  "rd_hex",  32'h0000_ABCD);
        rd(A_LEDR, "rd_ledr", 32'h0000_03FF);
        rd(A_LEDG, "rd_ledg", 32'h0000_00A5);

        st(A_SW,  32'hFFFF_FFFF);
        st(A_UNM, 32'hFFFF_FFFF);
        check_eq("hex_keep",  {16'h0, hex_out},  32'h0000_ABCD);
        check_eq("ledr_keep", {22'h0, ledr_out}, 32'h0000_03FF);
        check_eq("ledg_keep", {24'h0, ledg_out}, 32'h0000_00A5);
        rd(A_UNM, "rd_unmapped", 32'h0);
        rd(A_SW,  "rd_sw_after_wr", 32'h0);

        // KEY0 pressed: visible after edge 7, not edge 6
        key_in = 4'b1110;
        repeat (6) tick();
        rd(A_KEY, "key_edge6", 32'h0);
        tick();
        rd(A_KEY, "key_edge7", 32'h1);

        // SW bounce then hold; only the final clean step qualifies
        sw_in = 10'h2A5;
        repeat (2) tick();
        sw_in = 10'h000;
        repeat (2) tick();
        sw_in = 10'h2A5;
        repeat (2) tick();
        rd(A_SW, "sw_bounce_mid", 32'h0);
        repeat (4) tick();
        rd(A_SW, "sw_edge6_after_hold", 32'h0);
        tick();
        rd(A_SW, "sw_edge7_after_hold", 32'h0000_02A5);

        // New SW change two counts in, then a one-cycle reset with a store
        sw_in = 10'h155;
        repeat (5) tick();
        rd(A_SW, "sw_pending_before_rst", 32'h0000_02A5);
        reset = 1'b1;
        addr = 32'h0000_0100; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1; rd_en = 1'b0;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        check_eq("hex_after_rst", {16'h0, hex_out}, 32'h0);
        rd(A_SW,  "sw_after_rst",  32'h0);
        rd(A_KEY, "key_after_rst", 32'h0);
        rd(32'h0000_0100, "store_in_rst_dropped", 32'h1234_5678);
        repeat (6) tick();
        rd(A_SW,  "sw_requal_edge6",  32'h0);
        rd(A_KEY, "key_requal_edge6", 32'h0);
        tick();
        rd(A_SW,  "sw_requal_edge7",  32'h0000_0155);
        rd(A_KEY, "key_requal_edge7", 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
